fpu_dp_div_arbiter: RTL

Shares one `fpu_dp_divider` instance between two requesters. The block handles valid/ready arbitration with round-robin fairness, registers the operands, and holds them stable for a programmable multicycle window. It then captures the quotient and flags into a response register tagged with the requester ID. It sits between the FPU issue logic and the combinational double-precision divider, so the divider can be constrained as a `DIV_CYCLES` multicycle path.

---
 rtl/fpu_dp_div_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_dp_div_arbiter.sv
// Two-requester round-robin front end for a shared combinational double-precision divider.
// Operands are held in registers for DIV_CYCLES clocks, then the quotient is captured with the requester ID.

module fpu_dp_divider (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] q,
  output logic        overflow,
  output logic        underflow
);
  // Round-to-nearest-even. Subnormal inputs are treated as zero and tiny results flush to zero.
  function automatic logic [53:0] round_rne(input logic [52:0] mant, input logic guard,
                                            input logic sticky);
    return {1'b0, mant} + {53'd0, guard & (sticky | mant[0])};
  endfunction

  logic               sq;
  logic [10:0]        ea, eb;
  logic [52:0]        ma, mb;
  logic [55:0]        quo;
  logic [53:0]        rem;
  logic [52:0]        mant;
  logic [53:0]        mant_r;
  logic               guard, sticky;
  logic signed [13:0] exp_s;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  always_comb begin
    sq     = a[63] ^ b[63];
    ea     = a[62:52];
    eb     = b[62:52];
    ma     = {1'b1, a[51:0]};
    mb     = {1'b1, b[51:0]};
    a_zero = (ea == 11'd0);
    b_zero = (eb == 11'd0);
    a_inf  = (&ea) & ~(|a[51:0]);
    b_inf  = (&eb) & ~(|b[51:0]);
    a_nan  = (&ea) & (|a[51:0]);
    b_nan  = (&eb) & (|b[51:0]);
    quo    = '0;
    rem    = {1'b0, ma};
    // Restoring division: quo[55] carries the integer bit of ma/mb.
    for (int i = 55; i >= 0; i--) begin
      if (rem >= {1'b0, mb}) begin
        quo[i] = 1'b1;
        rem    = rem - {1'b0, mb};
      end
      rem = {rem[52:0], 1'b0};
    end
    exp_s = $signed({3'b000, ea}) - $signed({3'b000, eb}) + 14'sd1023;
    if (quo[55]) begin
      mant   = quo[55:3];
      guard  = quo[2];
      sticky = (|quo[1:0]) | (|rem);
    end else begin
      mant   = quo[54:2];
      guard  = quo[1];
      sticky = quo[0] | (|rem);
      exp_s  = exp_s - 14'sd1;
    end
    mant_r = round_rne(mant, guard, sticky);
    if (mant_r[53]) begin
      mant_r = mant_r >> 1;
      exp_s  = exp_s + 14'sd1;
    end
    overflow  = 1'b0;
    underflow = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      q = {1'b0, 11'h7ff, 1'b1, 51'd0};
    end else if (a_inf || b_zero) begin
      q = {sq, 11'h7ff, 52'd0};
    end else if (a_zero || b_inf) begin
      q = {sq, 63'd0};
    end else if (exp_s >= 14'sd2047) begin
      overflow = 1'b1;
      q        = {sq, 11'h7ff, 52'd0};
    end else if (exp_s <= 14'sd0) begin
      underflow = 1'b1;
      q         = {sq, 63'd0};
    end else begin
      q = {sq, exp_s[10:0], mant_r[51:0]};
    end
  end
endmodule

module fpu_dp_div_arbiter #(
  parameter int WIDTH      = 64,
  parameter int DIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_overflow,
  output logic             rsp_underflow,
  output logic             rsp_div_by_zero,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             id_q, id_d, dz_q, dz_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_ovf_q, rsp_ovf_d, rsp_unf_q, rsp_unf_d, rsp_dz_q, rsp_dz_d;
  logic             grant0, grant1, accept;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] div_q;
  logic             div_ovf, div_unf;

  fpu_dp_divider u_div (
    .a         (a_q),
    .b         (b_q),
    .q         (div_q),
    .overflow  (div_ovf),
    .underflow (div_unf)
  );

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant_q);
    grant1 = req1_valid & (~req0_valid | ~last_grant_q);
  end

  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;
  assign b_sel      = grant1 ? req1_b : req0_b;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    dz_d         = dz_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_unf_d    = rsp_unf_q;
    rsp_dz_d     = rsp_dz_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = BUSY;
          cnt_d        = CNT_LOAD;
          last_grant_d = grant1;
          id_d         = grant1;
          a_d          = grant1 ? req1_a : req0_a;
          b_d          = b_sel;
          dz_d         = (b_sel[WIDTH-2:0] == '0);
        end
      end
      BUSY: begin
        // Operands have now been stable at the divider for DIV_CYCLES clocks.
        if (cnt_q == 4'd0) begin
          state_d      = DONE;
          rsp_result_d = div_q;
          rsp_ovf_d    = div_ovf;
          rsp_unf_d    = div_unf;
          rsp_id_d     = id_q;
          rsp_dz_d     = dz_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      dz_q         <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_unf_q    <= 1'b0;
      rsp_dz_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      dz_q         <= dz_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_unf_q    <= rsp_unf_d;
      rsp_dz_q     <= rsp_dz_d;
    end
  end

  assign rsp_valid       = (state_q == DONE);
  assign busy            = (state_q != IDLE);
  assign rsp_id          = rsp_id_q;
  assign rsp_result      = rsp_result_q;
  assign rsp_overflow    = rsp_ovf_q;
  assign rsp_underflow   = rsp_unf_q;
  assign rsp_div_by_zero = rsp_dz_q;
endmodule
